// File: rtl/rca_error_monitor.sv
// rca_error_monitor
// Streaming error-metric collector for an approximate ripple-carry adder.
// Each accepted beat is re-added exactly (stage 1). Its error distance is
// then folded into the window statistics (stage 2): the erroneous-sample
// count, the saturating ED sum and, optionally, the maximum ED. After WINDOW
// accepted samples the result is offered on a valid/ready handshake.
//
// Build option: define RCA_ERRMON_MAXED_EN to build the max-ED tracker;
// without it ed_max is tied to zero.

module rca_error_monitor #(
    parameter int N      = 8,
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16,
    parameter int ACC_W  = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             cin,
    input  logic [N-1:0]     sum_apx,
    input  logic             cout_apx,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [N:0]       ed_max,
    output logic             sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Sample index of the final beat in a window.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    // Unsigned distance between two N+1-bit values: compare, then subtract
    // the smaller from the larger so no sign bit is needed.
    function automatic logic [N:0] abs_diff(input logic [N:0] x, input logic [N:0] y);
        logic [N:0] d;
        if (x >= y) begin
            d = x - y;
        end else begin
            d = y - x;
        end
        return d;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic               accept_s;
    logic               start_idle_s;
    logic               last_beat_s;
    logic [CNT_W-1:0]   smp_cnt_r;
    logic               s1_vld_r;
    logic [N:0]         exact_r;
    logic [N:0]         apx_r;
    logic [N:0]         exact_s;
    logic [N:0]         ed_s;
    logic [ACC_W:0]     sum_wide_s;
    logic [ACC_W-1:0]   sum_nxt_s;
    logic               ovf_s;
    logic [CNT_W-1:0]   err_cnt_r;
    logic [ACC_W-1:0]   ed_sum_r;
    logic               sat_r;

    // Handshake decodes come straight from the state register so in_ready
    // never depends combinationally on in_valid.
    assign accept_s     = in_valid & (state_r == S_ACCUM);
    assign start_idle_s = start & (state_r == S_IDLE);
    assign last_beat_s  = accept_s & (smp_cnt_r == LAST_IDX);
    assign exact_s      = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

    assign in_ready  = (state_r == S_ACCUM);
    assign busy      = (state_r != S_IDLE);
    assign res_valid = (state_r == S_DONE);
    assign err_cnt   = err_cnt_r;
    assign ed_sum    = ed_sum_r;
    assign sat       = sat_r;

    // Measurement control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; DRAIN lasts exactly one edge so stage 2 absorbs the last sample.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_ACCUM;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (last_beat_s) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_ACCUM;
                end
            end
            S_DRAIN: begin
                state_s = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Accepted-beat counter; bubbles leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt_r <= {CNT_W{1'b0}};
        end else if (start_idle_s) begin
            smp_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            smp_cnt_r <= smp_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            smp_cnt_r <= smp_cnt_r;
        end
    end

    // Stage 1: capture the exact and approximate results of each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r <= 1'b0;
            exact_r  <= {(N+1){1'b0}};
            apx_r    <= {(N+1){1'b0}};
        end else if (accept_s) begin
            s1_vld_r <= 1'b1;
            exact_r  <= exact_s;
            apx_r    <= {cout_apx, sum_apx};
        end else begin
            s1_vld_r <= 1'b0;
            exact_r  <= exact_r;
            apx_r    <= apx_r;
        end
    end

    // Stage 2 arithmetic: error distance and the saturating running sum.
    always_comb begin
        ed_s       = abs_diff(exact_r, apx_r);
        sum_wide_s = {1'b0, ed_sum_r} + {{(ACC_W-N){1'b0}}, ed_s};
        if (sum_wide_s[ACC_W]) begin
            sum_nxt_s = {ACC_W{1'b1}};
            ovf_s     = 1'b1;
        end else begin
            sum_nxt_s = sum_wide_s[ACC_W-1:0];
            ovf_s     = 1'b0;
        end
    end

    // Stage 2 accumulators: error count, ED sum and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= {CNT_W{1'b0}};
            ed_sum_r  <= {ACC_W{1'b0}};
            sat_r     <= 1'b0;
        end else if (start_idle_s) begin
            err_cnt_r <= {CNT_W{1'b0}};
            ed_sum_r  <= {ACC_W{1'b0}};
            sat_r     <= 1'b0;
        end else if (s1_vld_r) begin
            err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, (ed_s != {(N+1){1'b0}})};
            ed_sum_r  <= sum_nxt_s;
            sat_r     <= sat_r | ovf_s;
        end else begin
            err_cnt_r <= err_cnt_r;
            ed_sum_r  <= ed_sum_r;
            sat_r     <= sat_r;
        end
    end

`ifdef RCA_ERRMON_MAXED_EN
    logic [N:0] ed_max_r;

    // Largest error distance seen in the current window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ed_max_r <= {(N+1){1'b0}};
        end else if (start_idle_s) begin
            ed_max_r <= {(N+1){1'b0}};
        end else if (s1_vld_r && (ed_s > ed_max_r)) begin
            ed_max_r <= ed_s;
        end else begin
            ed_max_r <= ed_max_r;
        end
    end

    assign ed_max = ed_max_r;
`else
    assign ed_max = {(N+1){1'b0}};
`endif

endmodule

// File: tb/tb_rca_error_monitor.sv
// Bench for rca_error_monitor: four instances with different WINDOW/ACC_W
// share the beat inputs; each has its own start. Expected window results
// are queued when a window is driven and popped on each result handshake.

module tb_rca_error_monitor;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] apx;
        int         ed;
    } vec_t;

    typedef struct {
        int inst;
        int cnt;
        int sum;
        int mx;
        int sat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        iv;
    logic        cin;
    logic        cout_apx;
    logic        res_ready;
    logic [3:0]  st;
    logic [3:0]  ir;
    logic [3:0]  rv;
    logic [3:0]  sat_o;
    logic [3:0]  bz;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  sum_apx;
    logic [15:0] ec [4];
    logic [8:0]  em [4];
    logic [23:0] es [3];
    logic [8:0]  es_sat;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   hs_cnt  = 0;
    exp_t sb_q[$];
    vec_t tbl [12];
    vec_t cur[$];
    bit   vpat[$];
    vec_t junk;

    rca_error_monitor #(.N(8), .WINDOW(4), .CNT_W(16), .ACC_W(24)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(iv), .in_ready(ir[0]),
        .a(a), .b(b), .cin(cin), .sum_apx(sum_apx), .cout_apx(cout_apx),
        .res_valid(rv[0]), .res_ready(res_ready), .err_cnt(ec[0]), .ed_sum(es[0]),
        .ed_max(em[0]), .sat(sat_o[0]), .busy(bz[0]));

    rca_error_monitor #(.N(8), .WINDOW(2), .CNT_W(16), .ACC_W(24)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(iv), .in_ready(ir[1]),
        .a(a), .b(b), .cin(cin), .sum_apx(sum_apx), .cout_apx(cout_apx),
        .res_valid(rv[1]), .res_ready(res_ready), .err_cnt(ec[1]), .ed_sum(es[1]),
        .ed_max(em[1]), .sat(sat_o[1]), .busy(bz[1]));

    rca_error_monitor #(.N(8), .WINDOW(4), .CNT_W(16), .ACC_W(9)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .in_valid(iv), .in_ready(ir[2]),
        .a(a), .b(b), .cin(cin), .sum_apx(sum_apx), .cout_apx(cout_apx),
        .res_valid(rv[2]), .res_ready(res_ready), .err_cnt(ec[2]), .ed_sum(es_sat),
        .ed_max(em[2]), .sat(sat_o[2]), .busy(bz[2]));

    rca_error_monitor #(.N(8), .WINDOW(3), .CNT_W(16), .ACC_W(24)) u_w3 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .in_valid(iv), .in_ready(ir[3]),
        .a(a), .b(b), .cin(cin), .sum_apx(sum_apx), .cout_apx(cout_apx),
        .res_valid(rv[3]), .res_ready(res_ready), .err_cnt(ec[3]), .ed_sum(es[2]),
        .ed_max(em[3]), .sat(sat_o[3]), .busy(bz[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sum_of(input int k);
        logic [31:0] r;
        case (k)
            0:       r = {8'd0, es[0]};
            1:       r = {8'd0, es[1]};
            2:       r = {23'd0, es_sat};
            default: r = {8'd0, es[2]};
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_beat(input vec_t v);
        a = v.a;
        b = v.b;
        cin = v.cin;
        {cout_apx, sum_apx} = v.apx;
    endtask

    // Scoreboard check on every result handshake.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rv[k] && res_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: result on instance %0d with empty queue", k);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_inst", k, e.inst);
                    chk("sb_err_cnt", {16'd0, ec[k]}, e.cnt);
                    chk("sb_ed_sum", sum_of(k), e.sum);
                    chk("sb_ed_max", {23'd0, em[k]}, e.mx);
                    chk("sb_sat", {31'd0, sat_o[k]}, e.sat);
                end
                hs_cnt++;
            end
        end
    end

    // Run one window on instance k using cur/vpat; bp holds res_ready low in DONE.
    task automatic run(input int k, input bit bp);
        exp_t e;
        int   accmax;
        int   s;
        int   j;
        int   tgt;
        accmax = (k == 2) ? 511 : 16777215;
        e = '{k, 0, 0, 0, 0};
        foreach (cur[i]) begin
            if (cur[i].ed != 0) e.cnt++;
            s = e.sum + cur[i].ed;
            if (s > accmax) begin
                s = accmax;
                e.sat = 1;
            end
            e.sum = s;
`ifdef RCA_ERRMON_MAXED_EN
            if (cur[i].ed > e.mx) e.mx = cur[i].ed;
`endif
        end
        sb_q.push_back(e);
        res_ready = !bp;
        st[k] = 1'b1;
        @(posedge clk); #1;
        st[k] = 1'b0;
        chk("start_in_ready", {31'd0, ir[k]}, 1);
        chk("start_busy", {31'd0, bz[k]}, 1);
        j = 0;
        for (int i = 0; i < vpat.size(); i++) begin
            iv = vpat[i];
            if (vpat[i]) begin
                drive_beat(cur[j]);
                j++;
            end else begin
                drive_beat(junk);
            end
            @(posedge clk); #1;
            if (i < vpat.size() - 1) chk("accum_in_ready", {31'd0, ir[k]}, 1);
        end
        iv = 1'b0;
        chk("drain_in_ready", {31'd0, ir[k]}, 0);
        chk("drain_busy", {31'd0, bz[k]}, 1);
        chk("drain_res_valid", {31'd0, rv[k]}, 0);
        @(posedge clk); #1;
        chk("done_res_valid", {31'd0, rv[k]}, 1);
        tgt = hs_cnt + 1;
        if (bp) begin
            for (int c = 0; c < 10; c++) begin
                st[k] = 1'b1;
                iv = 1'b1;
                drive_beat(junk);
                @(posedge clk); #1;
                chk("bp_res_valid", {31'd0, rv[k]}, 1);
                chk("bp_in_ready", {31'd0, ir[k]}, 0);
                chk("bp_err_cnt", {16'd0, ec[k]}, e.cnt);
                chk("bp_ed_sum", sum_of(k), e.sum);
            end
            st[k] = 1'b0;
            iv = 1'b0;
            res_ready = 1'b1;
        end
        for (int c = 0; c < 10 && hs_cnt < tgt; c++) begin
            @(negedge clk); #1;
        end
        if (hs_cnt < tgt) begin
            n_tests++;
            n_fail++;
            $display("FAIL result_timeout: instance %0d gave no handshake", k);
        end
        @(posedge clk); #1;
        chk("idle_busy", {31'd0, bz[k]}, 0);
        chk("idle_res_valid", {31'd0, rv[k]}, 0);
        chk("idle_keep_err_cnt", {16'd0, ec[k]}, e.cnt);
        chk("idle_keep_ed_sum", sum_of(k), e.sum);
    endtask

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'd3,   8'd4,   1'b0, 9'd7,   0};
        tbl[1]  = '{8'd255, 8'd1,   1'b0, 9'd256, 0};
        tbl[2]  = '{8'd17,  8'd34,  1'b1, 9'd52,  0};
        tbl[3]  = '{8'd200, 8'd200, 1'b1, 9'd401, 0};
        tbl[4]  = '{8'd10,  8'd20,  1'b0, 9'd30,  0};
        tbl[5]  = '{8'd255, 8'd255, 1'b1, 9'd511, 0};
        tbl[6]  = '{8'd100, 8'd50,  1'b1, 9'd140, 11};
        tbl[7]  = '{8'd0,   8'd0,   1'b0, 9'd5,   5};
        tbl[8]  = '{8'd200, 8'd100, 1'b0, 9'd44,  256};
        tbl[9]  = '{8'd1,   8'd1,   1'b1, 9'd511, 508};
        tbl[10] = '{8'd128, 8'd128, 1'b0, 9'd256, 0};
        tbl[11] = '{8'd15,  8'd16,  1'b0, 9'd30,  1};
        junk    = '{8'd255, 8'd255, 1'b1, 9'd0,   511};

        rst_n = 1'b0;
        st = 4'd0;
        iv = 1'b0;
        res_ready = 1'b1;
        drive_beat(junk);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {28'd0, ir}, 0);
        chk("reset_busy", {28'd0, bz}, 0);
        chk("reset_res_valid", {28'd0, rv}, 0);
        chk("reset_err_cnt", {16'd0, ec[0]}, 0);
        chk("reset_ed_sum", sum_of(0), 0);
        rst_n = 1'b1;

        // Reset abort in the middle of ACCUM.
        @(posedge clk); #1;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        iv = 1'b1;
        drive_beat(tbl[8]);
        @(posedge clk); #1;
        drive_beat(tbl[9]);
        @(posedge clk); #1;
        iv = 1'b0;
        chk("pre_abort_ed_sum", sum_of(0), 256);
        chk("pre_abort_in_ready", {31'd0, ir[0]}, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, ir[0]}, 0);
        chk("abort_busy", {31'd0, bz[0]}, 0);
        chk("abort_res_valid", {31'd0, rv[0]}, 0);
        chk("abort_err_cnt", {16'd0, ec[0]}, 0);
        chk("abort_ed_sum", sum_of(0), 0);
        chk("abort_ed_max", {23'd0, em[0]}, 0);
        chk("abort_sat", {31'd0, sat_o[0]}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table windows: exact adder, mixed errors, large errors.
        for (int w = 0; w < 3; w++) begin
            cur.delete();
            vpat.delete();
            for (int i = 0; i < 4; i++) begin
                cur.push_back(tbl[w * 4 + i]);
                vpat.push_back(1'b1);
            end
            run(0, 1'b0);
        end

        // Known errors, WINDOW=2.
        cur.delete();
        vpat.delete();
        cur.push_back('{8'hFF, 8'h01, 1'b0, 9'h000, 256});
        cur.push_back('{8'h03, 8'h04, 1'b0, 9'h006, 1});
        vpat = '{1'b1, 1'b1};
        run(1, 1'b0);

        // Saturation, ACC_W=9, ED=256 on every beat.
        cur.delete();
        vpat.delete();
        for (int i = 0; i < 4; i++) begin
            cur.push_back('{8'hFF, 8'h01, 1'b0, 9'h000, 256});
            vpat.push_back(1'b1);
        end
        run(2, 1'b0);

        // Bubbles, WINDOW=3, valid pattern 1,0,0,1,0,1.
        cur.delete();
        vpat.delete();
        cur.push_back('{8'd1,  8'd2,  1'b0, 9'd4,   1});
        cur.push_back('{8'd10, 8'd10, 1'b0, 9'd18,  2});
        cur.push_back('{8'd50, 8'd60, 1'b1, 9'd114, 3});
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run(3, 1'b0);

        // Backpressure in DONE with start and in_valid pulsed.
        cur.delete();
        vpat.delete();
        for (int i = 8; i < 12; i++) begin
            cur.push_back(tbl[i]);
            vpat.push_back(1'b1);
        end
        run(0, 1'b1);

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
